// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: streams host configuration words LSB-first into a ccff chain.
// Define CCFF_READBACK_EN to add a CRC-checked rotate-back VERIFY pass.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 36,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              shift_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int SC_W  = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
`ifdef CCFF_READBACK_EN
    localparam logic [1:0] S_VERIFY = 2'd2;
`endif
    localparam logic [1:0] S_DONE   = 2'd3;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        crc_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [WORD_W-1:0] r_sr;
    logic [SC_W-1:0]   r_sr_cnt;
    logic [WORD_W-1:0] r_buf;
    logic              r_buf_full;
    logic [15:0]       r_crc;

    logic w_load_shift;
    logic w_last_load;
    logic w_accept;
    logic w_sr_free;

    assign w_load_shift = (r_state == S_LOAD) && (r_sr_cnt != '0);
    assign w_last_load  = w_load_shift && (r_cnt == LAST_BIT);
    assign cfg_ready    = (r_state == S_LOAD) && !r_buf_full;
    assign w_accept     = cfg_valid && cfg_ready;
    // Shift register counts as free when it is empty or its last bit leaves this edge,
    // which lets a buffered word follow with no shift_en gap.
    assign w_sr_free    = (r_sr_cnt == '0) || (w_load_shift && (r_sr_cnt == SC_W'(1)));
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);

`ifdef CCFF_READBACK_EN
    logic        w_verify;
    logic [15:0] r_crc_rb;
    logic        r_err;

    assign w_verify  = (r_state == S_VERIFY);
    assign shift_en  = w_load_shift || w_verify;
    assign ccff_head = w_verify ? ccff_tail : (w_load_shift && r_sr[0]);
    assign err       = r_err;
`else
    logic w_unused_tail;

    assign w_unused_tail = ccff_tail;
    assign shift_en      = w_load_shift;
    assign ccff_head     = w_load_shift && r_sr[0];
    assign err           = 1'b0;
`endif

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_sr       <= '0;
            r_sr_cnt   <= '0;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_crc      <= 16'hFFFF;
`ifdef CCFF_READBACK_EN
            r_crc_rb   <= 16'hFFFF;
            r_err      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_LOAD;
                        r_cnt      <= '0;
                        r_sr_cnt   <= '0;
                        r_buf_full <= 1'b0;
                        r_crc      <= 16'hFFFF;
`ifdef CCFF_READBACK_EN
                        r_crc_rb   <= 16'hFFFF;
                        r_err      <= 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    if (w_load_shift) begin
                        r_sr     <= r_sr >> 1;
                        r_sr_cnt <= r_sr_cnt - SC_W'(1);
                        r_cnt    <= r_cnt + CNT_W'(1);
                        r_crc    <= crc_step(r_crc, r_sr[0]);
                    end
                    if (r_buf_full && w_sr_free) begin
                        r_sr       <= r_buf;
                        r_sr_cnt   <= SC_W'(WORD_W);
                        r_buf_full <= 1'b0;
                    end else if (w_accept) begin
                        r_buf      <= cfg_data;
                        r_buf_full <= 1'b1;
                    end
                    // Final chain bit: drop leftover word bits and any buffered word.
                    if (w_last_load) begin
`ifdef CCFF_READBACK_EN
                        r_state    <= S_VERIFY;
`else
                        r_state    <= S_DONE;
`endif
                        r_cnt      <= '0;
                        r_sr_cnt   <= '0;
                        r_buf_full <= 1'b0;
                    end
                end
`ifdef CCFF_READBACK_EN
                S_VERIFY: begin
                    r_crc_rb <= crc_step(r_crc_rb, ccff_tail);
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_BIT) begin
                        r_cnt   <= '0;
                        r_err   <= (crc_step(r_crc_rb, ccff_tail) != r_crc);
                        r_state <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
